// File: rtl/fm_skew_feeder_pkg.sv
// Shared types and lane width for the systolic-array skew feeder.
// The optional stall counter is enabled with FEEDER_STALL_CNT_EN.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

package fm_skew_feeder_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_FLUSH  = 2'd2
  } feed_state_e;

  localparam int unsigned STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/fm_skew_feeder_skew_lane.sv
// DEPTH-stage register chain carrying one lane's data and valid together.
// Cleared asynchronously so an aborted tile disappears from the array edge at once.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module skew_lane #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = `WIDTH_DATA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  input  logic         vld_i,
  output logic [W-1:0] data_o,
  output logic         vld_o
);

  logic [W-1:0] data_q [DEPTH];
  logic         vld_q  [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      data_q[0] <= data_i;
      vld_q[0]  <= vld_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign data_o = data_q[DEPTH-1];
  assign vld_o  = vld_q[DEPTH-1];

endmodule

// File: rtl/fm_skew_feeder.sv
// Feeds feature-map beats into the PE array with lane r delayed r cycles, framed in K_LEN-beat tiles.
// Optional feature: FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module fm_skew_feeder
  import fm_skew_feeder_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned K_LEN = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ROWS*`WIDTH_DATA-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ROWS*`WIDTH_DATA-1:0] fm_out,
  output logic [ROWS-1:0]             fm_vld,
  output logic                        busy,
  output logic                        tile_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]          stall_cnt
`endif
);

  localparam int unsigned W = `WIDTH_DATA;
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(K_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  feed_state_e      state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             tile_done_q;

  logic                accept;
  logic [ROWS*W-1:0]   entry_data_d;

  assign accept       = in_ready_q & in_valid;
  assign entry_data_d = accept ? in_data : '0;

  // in_ready and busy are registered alongside the state so they carry no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FEED_IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      unique case (state_q)
        FEED_IDLE: begin
          if (start) begin
            state_q    <= FEED_STREAM;
            beat_cnt_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FEED_STREAM: begin
          if (accept) begin
            if (beat_cnt_q == BEAT_LAST) begin
              state_q     <= FEED_FLUSH;
              flush_cnt_q <= '0;
              in_ready_q  <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_ONE;
            end
          end
        end
        FEED_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q     <= FEED_IDLE;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q    <= FEED_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign tile_done = tile_done_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_lane #(
      .DEPTH(r + 1),
      .W    (W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .data_i(entry_data_d[r*W +: W]),
      .vld_i (accept),
      .data_o(fm_out[r*W +: W]),
      .vld_o (fm_vld[r])
    );
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (state_q == FEED_IDLE && start) begin
      stall_cnt_q <= '0;
    end else if (state_q == FEED_STREAM && !in_valid && stall_cnt_q != STALL_MAX) begin
      stall_cnt_q <= stall_cnt_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fm_skew_feeder.sv
// Scoreboard bench for fm_skew_feeder (ROWS=4, K_LEN=3, 8-bit lanes) with a tile-level reference model.
// Build with FEEDER_STALL_CNT_EN defined to also check stall_cnt.
module tb_fm_skew_feeder;

  localparam int ROWS  = 4;
  localparam int K_LEN = 3;
  localparam int W     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [ROWS*W-1:0] in_data = '0;
  logic              in_ready;
  logic [ROWS*W-1:0] fm_out;
  logic [ROWS-1:0]   fm_vld;
  logic              busy;
  logic              tile_done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  fm_skew_feeder #(.ROWS(ROWS), .K_LEN(K_LEN), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fm_out   (fm_out),
    .fm_vld   (fm_vld),
    .busy     (busy),
    .tile_done(tile_done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    int          edge_n;
    logic [W-1:0] data;
  } lane_exp_t;

  lane_exp_t lane_q [ROWS][$];
  int        done_q [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Tile-level model: a tile is active, takes K_LEN beats, then ROWS drain cycles.
  bit m_active = 1'b0;
  int m_beats_left = 0;
  int m_flush_left = 0;
  int m_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (!m_active) begin
        if (start) begin
          m_active     = 1'b1;
          m_beats_left = K_LEN;
          m_stall      = 0;
        end
      end else if (m_beats_left > 0) begin
        if (in_valid) begin
          for (int r = 0; r < ROWS; r++) begin
            lane_exp_t x;
            x.edge_n = cyc + r;
            x.data   = in_data[r*W +: W];
            lane_q[r].push_back(x);
          end
          m_beats_left--;
          if (m_beats_left == 0) m_flush_left = ROWS;
        end else if (m_stall < 65535) begin
          m_stall++;
        end
      end else begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_active = 1'b0;
          done_q.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_fm_out", fm_out, '0);
      check("rst_fm_vld", fm_vld, '0);
      check("rst_busy", busy, '0);
      check("rst_in_ready", in_ready, '0);
      check("rst_tile_done", tile_done, '0);
`ifdef FEEDER_STALL_CNT_EN
      check("rst_stall_cnt", stall_cnt, '0);
`endif
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (fm_vld[r]) begin
          if (lane_q[r].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL lane%0d_unexpected_valid: got data %0h, expected no valid (cycle %0d)",
                     r, fm_out[r*W +: W], cyc);
          end else begin
            lane_exp_t e;
            e = lane_q[r].pop_front();
            check($sformatf("lane%0d_cycle", r), cyc, e.edge_n);
            check($sformatf("lane%0d_data", r), fm_out[r*W +: W], e.data);
          end
        end else begin
          check($sformatf("lane%0d_bubble_zero", r), fm_out[r*W +: W], '0);
        end
      end
      if (tile_done) begin
        if (done_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tile_done_unexpected: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          check("tile_done_cycle", cyc, done_q.pop_front());
        end
      end
      check("busy", busy, m_active);
      check("in_ready", in_ready, (m_active && m_beats_left > 0));
`ifdef FEEDER_STALL_CNT_EN
      check("stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  task automatic drive(input logic s, input logic v);
    @(posedge clk);
    #1;
    start    = s;
    in_valid = v;
    in_data  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  initial begin
    // Reset held, then released with no start.
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    // Back-to-back tile.
    drive(1'b1, 1'b0);
    for (int i = 0; i < K_LEN; i++) drive(1'b0, 1'b1);
    idle(10);

    // Two-cycle bubble between A and B.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    idle(10);

    // start pulses during STREAM and FLUSH.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    idle(10);

    // Chained tiles: start held so it is honoured in each tile_done cycle.
    for (int i = 0; i < 3 * (K_LEN + ROWS + 1); i++) drive(1'b1, 1'b1);
    idle(12);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
    idle(12);

    // Abort after two beats.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    m_active     = 1'b0;
    m_beats_left = 0;
    m_flush_left = 0;
    m_stall      = 0;
    for (int r = 0; r < ROWS; r++) lane_q[r].delete();
    done_q.delete();
    #1;
    check("abort_fm_out", fm_out, '0);
    check("abort_fm_vld", fm_vld, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(12);

    // Recovery tile after the abort, then more random traffic.
    drive(1'b1, 1'b0);
    for (int i = 0; i < K_LEN; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
    idle(20);

    for (int r = 0; r < ROWS; r++)
      check($sformatf("lane%0d_undelivered", r), lane_q[r].size(), 0);
    check("tile_done_missing", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
